lc3_fetch_unit: RTL
===================

# lc3_fetch_unit

Instruction-fetch sequencer for the LC-3 datapath, sitting directly downstream of the program counter. On request from the control FSM it latches the current PC into MAR and drives a read to memory. It tells the PC to advance (PC+1 select, load), waits for memory to respond, and captures the returned word into IR. It then pulses completion so decode can proceed.

## Interface
- TIMEOUT_CYCLES, 15: maximum cycles spent in REQ+WAIT before a fetch is aborted (used only when the timeout feature is compiled in); legal range 1..255.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  control FSM requests one instruction fetch.
- flush  in  1  abort any fetch in progress; highest priority after rst.
- pc  in  16  current PC value from the PC register.
- mem_rdata  in  16  read data from memory; valid only when mem_ready=1.
- mem_ready  in  1  memory has completed the read this cycle.
- mar  out  16  memory address register, driven to memory address.
- mem_en  out  1  read request to memory, held until mem_ready or abort.
- pc_inc  out  1  one-cycle pulse to the PC: select PC+1 and load.
- ir  out  16  instruction register.
- busy  out  1  high in REQ, WAIT, DONE.
- fetch_done  out  1  one-cycle pulse; ir holds the new instruction.
- fetch_err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start=1 -> REQ, mar<=pc at the same edge.
- REQ: mem_en=1, pc_inc=1 (exactly one cycle per fetch). mem_ready=1 -> ir<=mem_rdata, -> DONE; else -> WAIT.
- WAIT: mem_en=1, pc_inc=0. mem_ready=1 -> ir<=mem_rdata, -> DONE.
- DONE: fetch_done=1. start=1 -> REQ with mar<=pc (back-to-back; pc already holds the incremented value); else -> IDLE.
- flush=1 in any state: -> IDLE next edge. ir and mar are not written. No fetch_done. A pc_inc already issued is not undone; control reloads the PC.
- flush and mem_ready in the same cycle: flush wins, ir is unchanged.
- start and flush in the same cycle: flush wins, no fetch starts.
- start in REQ/WAIT: ignored.
- mem_ready outside REQ/WAIT: ignored.
- All data is 16-bit; no arithmetic in this block. The increment lives in the PC.

## Timing
- Reset values: state IDLE, mar=0x0000, ir=0x0000, mem_en=0, pc_inc=0, busy=0, fetch_done=0, fetch_err=0.
- Zero-wait memory: start sampled at edge 0 -> REQ in cycle 1 -> fetch_done in cycle 2. Latency is 2 cycles; back-to-back throughput is 1 fetch per 2 cycles.
- Each cycle mem_ready is low in REQ/WAIT adds one cycle of latency.
- mem_en and mar are stable from the REQ edge until the capture or abort edge.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Configuration
- LC3_FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ/WAIT cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES: -> IDLE, fetch_err pulses 1 cycle, ir is unchanged.
  - mem_ready in the same cycle as expiry wins: the fetch completes normally.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter, fetch_err tied 0, WAIT persists indefinitely until mem_ready or flush.

## Structure
- Shared package lc3_pkg holds:
  - LC3_WORD_W=16
  - fetch_state_t enum {IDLE, REQ, WAIT, DONE}
  - IR reset constant 16'h0000
- Sub-module lc3_fetch_timer holds the watchdog counter:
  - Inputs: clk, rst, clear, tick. Output: expired.
  - Instantiated only under LC3_FETCH_TIMEOUT_EN.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, mar=0x0000, ir=0x0000.
- pc=0x3000, start pulse, mem_ready=1 in REQ with rdata=0x1261 -> mar=0x3000, one pc_inc, ir=0x1261, fetch_done 2 cycles after start.
- pc=0x3001, mem_ready delayed 3 cycles, rdata=0xABCD -> mem_en high 4 cycles, pc_inc exactly once, ir=0xABCD, fetch_done at cycle 5.
- start held high across DONE with pc=0x3001 then 0x3002 -> two fetches, mar sequence 0x3001, 0x3002, fetch_done every 2nd cycle.
- flush asserted in WAIT coincident with mem_ready, rdata=0xFFFF -> IDLE next cycle, ir keeps its prior value, no fetch_done.
- With LC3_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted -> fetch_err pulse 4 cycles after REQ entry, return to IDLE, ir unchanged; without the macro the FSM stays in WAIT for 100 cycles.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants used by the fetch unit and its watchdog.
package lc3_pkg;

    localparam int LC3_WORD_W = 16;
    localparam logic [LC3_WORD_W-1:0] LC3_IR_RESET = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_timer.sv
// Watchdog counter for an outstanding fetch; expired is asserted in the cycle whose
// stall would bring the count up to TIMEOUT_CYCLES.
module lc3_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Look one increment ahead so the abort lands on the edge where the count hits the limit.
    assign expired = tick && !clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction-fetch sequencer: PC -> MAR, memory read, capture into IR.
// Define LC3_FETCH_TIMEOUT_EN to build in the REQ/WAIT watchdog and fetch_err reporting.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [LC3_WORD_W-1:0] pc,
    input  logic [LC3_WORD_W-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [LC3_WORD_W-1:0] mar,
    output logic                  mem_en,
    output logic                  pc_inc,
    output logic [LC3_WORD_W-1:0] ir,
    output logic                  busy,
    output logic                  fetch_done,
    output logic                  fetch_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lc3_fetch_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    fetch_state_t          r_state;
    logic [LC3_WORD_W-1:0] r_mar;
    logic [LC3_WORD_W-1:0] r_ir;
    logic                  w_in_fetch;
    logic                  w_enter_req;
    logic                  w_expired;

    assign w_in_fetch  = (r_state == REQ) || (r_state == WAIT);
    assign w_enter_req = !flush && start && ((r_state == IDLE) || (r_state == DONE));

`ifdef LC3_FETCH_TIMEOUT_EN
    logic r_fetch_err;

    lc3_fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_enter_req),
        .tick   (w_in_fetch && !mem_ready),
        .expired(w_expired)
    );

    assign fetch_err = r_fetch_err;
`else
    assign w_expired = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mar   <= '0;
            r_ir    <= LC3_IR_RESET;
`ifdef LC3_FETCH_TIMEOUT_EN
            r_fetch_err <= 1'b0;
`endif
        end else begin
`ifdef LC3_FETCH_TIMEOUT_EN
            r_fetch_err <= 1'b0;
`endif
            // Flush beats everything, including a read that completes this very cycle.
            if (flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_state <= REQ;
                            r_mar   <= pc;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    REQ, WAIT: begin
                        if (mem_ready) begin
                            r_ir    <= mem_rdata;
                            r_state <= DONE;
                        end else if (w_expired) begin
                            r_state <= IDLE;
`ifdef LC3_FETCH_TIMEOUT_EN
                            r_fetch_err <= 1'b1;
`endif
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Remaining outputs decode from state only, keeping inputs off every output path.
    assign mar        = r_mar;
    assign ir         = r_ir;
    assign mem_en     = w_in_fetch;
    assign pc_inc     = (r_state == REQ);
    assign busy       = (r_state != IDLE);
    assign fetch_done = (r_state == DONE);

endmodule
